// File: rtl/det_engine_scheduler.sv
// Round-robin scheduler sharing one 8x8 determinant engine between two requesters.
// Launches jobs over the engine's Start/Ack handshake and aborts hung jobs via a BUSY watchdog.
module det_engine_scheduler #(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned CNT_W       = 13
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [255:0] mat0,
  input  logic [255:0] mat1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [31:0]  rsp_det,
  output logic         rsp_err,
  output logic         busy,
  output logic [255:0] eng_mat,
  output logic         eng_Start,
  output logic         eng_Ack,
  output logic         eng_Reset,
  input  logic [31:0]  eng_det,
  input  logic         eng_q_Enter,
  input  logic         eng_q_Done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_BUSY   = 3'd2,
    S_RETIRE = 3'd3,
    S_ABORT  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e         state_q, state_d;
  logic           rr_q, rr_d;
  logic           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [255:0]   mat_q, mat_d;
  logic [31:0]    det_q, det_d;
  logic           id_q, id_d;
  logic           err_q, err_d;
  logic           winner;

  // With both requesting the round-robin pointer decides; otherwise the lone requester wins.
  assign winner = (req0 && req1) ? rr_q : req1;

  always_comb begin
    // NOTE: every _d takes its _q value first, so no branch leaves a variable unassigned and no latch is inferred.
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    mat_d   = mat_q;
    det_d   = det_q;
    id_d    = id_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (eng_q_Enter && (req0 || req1)) begin
          owner_d = winner;
          rr_d    = ~winner;
          mat_d   = winner ? mat1 : mat0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A Done arriving on the last permitted cycle still completes normally.
        if (eng_q_Done) begin
          det_d   = eng_det;
          err_d   = 1'b0;
          id_d    = owner_q;
          state_d = S_RETIRE;
        end else if (cnt_q == CNT_LAST) begin
          det_d   = '0;
          err_d   = 1'b1;
          id_d    = owner_q;
          state_d = S_ABORT;
        end
      end
      S_RETIRE: state_d = S_IDLE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      mat_q   <= '0;
      det_q   <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      mat_q   <= mat_d;
      det_q   <= det_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign gnt0      = (state_q == S_ISSUE) && !owner_q;
  assign gnt1      = (state_q == S_ISSUE) &&  owner_q;
  assign eng_Start = (state_q == S_ISSUE);
  assign eng_Ack   = (state_q == S_RETIRE);
  assign rsp_valid = (state_q == S_RETIRE) || (state_q == S_ABORT);
  assign busy      = (state_q != S_IDLE);
  assign rsp_id    = id_q;
  assign rsp_det   = det_q;
  assign rsp_err   = err_q;
  assign eng_mat   = mat_q;
  // The engine is held in reset with the scheduler and kicked once when a job is aborted.
  assign eng_Reset = ~Reset | (state_q == S_ABORT);

endmodule
